// File: rtl/fb_write_ctrl_pkg.sv
// Shared definitions for the frame-buffer write path: FSM encodings, frame geometry
// constants and an elaboration helper for address-space sizing.
package fb_write_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_CAPTURE = 2'd2
    } fb_state_e;

    localparam int FB_AW    = 15;
    localparam int FB_DW    = 12;
    localparam int FB_H_RES = 160;
    localparam int FB_V_RES = 120;
    localparam int FB_NPIX  = FB_H_RES * FB_V_RES;

    function automatic bit npix_fits(input int npix, input int aw);
        return npix <= (1 << aw);
    endfunction

endpackage

// File: rtl/fb_write_ctrl_addr_counter.sv
// Linear write pointer: sync clear, enable, terminal-count flag at NPIX-1.
// Clear together with enable restarts the frame and consumes pixel 0 in one cycle.
module fb_addr_counter #(
    parameter int AW   = 15,
    parameter int NPIX = 19200
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] cnt,
    output logic          tc
);

    localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = en ? AW'(1) : '0;
        end else if (en && (cnt_q != LAST)) begin
            // Saturates at the last pixel rather than wrapping.
            cnt_d = cnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/fb_write_ctrl.sv
// Write-port arbiter for the frame buffer: shares one write port between the camera
// pixel stream and a whole-frame clear engine, generating linear write addresses.
module fb_write_ctrl
    import fb_write_ctrl_pkg::*;
#(
    parameter int AW    = FB_AW,
    parameter int DW    = FB_DW,
    parameter int H_RES = FB_H_RES,
    parameter int V_RES = FB_V_RES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          capture_en,
    input  logic          cam_frame_start,
    input  logic          cam_px_valid,
    input  logic [DW-1:0] cam_px_data,
    input  logic          clear_req,
    input  logic [DW-1:0] clear_color,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_we,
    output logic          busy,
    output logic          frame_done,
    output logic          frame_err,
    output logic          px_drop,
    output logic [1:0]    state_dbg
);

    localparam int NPIX = H_RES * V_RES;

    if (!npix_fits(NPIX, AW)) begin : g_npix_check
        $error("fb_write_ctrl: H_RES*V_RES does not fit in AW address bits");
    end

    fb_state_e     state_q, state_d;
    logic          clr_pend_q, clr_pend_d;
    logic [DW-1:0] clr_color_q, clr_color_d;

    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic          mem_we_q, mem_we_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d;
    logic          px_drop_q, px_drop_d;

    logic          cnt_clr;
    logic          cnt_en;
    logic [AW-1:0] ptr;
    logic          ptr_tc;

    fb_addr_counter #(
        .AW   (AW),
        .NPIX (NPIX)
    ) u_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (ptr),
        .tc    (ptr_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            clr_pend_q   <= 1'b0;
            clr_color_q  <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            px_drop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_pend_q   <= clr_pend_d;
            clr_color_q  <= clr_color_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            px_drop_q    <= px_drop_d;
        end
    end

    // Clear always wins over the camera in IDLE; a clear requested mid-capture waits.
    always_comb begin
        state_d     = state_q;
        clr_pend_d  = clr_pend_q;
        clr_color_d = clr_color_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req || clr_pend_q) begin
                    state_d     = ST_CLEAR;
                    clr_pend_d  = 1'b0;
                    clr_color_d = clear_color;
                end else if (capture_en && cam_frame_start) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CLEAR: begin
                if (ptr_tc) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (clear_req) begin
                    clr_pend_d = 1'b1;
                end
                if (!cam_frame_start && cam_px_valid && ptr_tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        px_drop_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_req || clr_pend_q) begin
                    cnt_clr   = 1'b1;
                    px_drop_d = cam_px_valid;
                end else if (capture_en && cam_frame_start) begin
                    cnt_clr = 1'b1;
                    if (cam_px_valid) begin
                        cnt_en     = 1'b1;
                        mem_we_d   = 1'b1;
                        mem_addr_d = '0;
                        mem_data_d = cam_px_data;
                    end
                end else begin
                    px_drop_d = cam_px_valid;
                end
            end
            ST_CLEAR: begin
                cnt_en       = 1'b1;
                mem_we_d     = 1'b1;
                mem_addr_d   = ptr;
                mem_data_d   = clr_color_q;
                frame_done_d = ptr_tc;
                px_drop_d    = cam_px_valid;
            end
            ST_CAPTURE: begin
                if (cam_frame_start) begin
                    // Short frame: restart at address 0, keeping any pixel that arrived with the start.
                    frame_err_d = 1'b1;
                    cnt_clr     = 1'b1;
                    if (cam_px_valid) begin
                        cnt_en     = 1'b1;
                        mem_we_d   = 1'b1;
                        mem_addr_d = '0;
                        mem_data_d = cam_px_data;
                    end
                end else if (cam_px_valid) begin
                    cnt_en       = 1'b1;
                    mem_we_d     = 1'b1;
                    mem_addr_d   = ptr;
                    mem_data_d   = cam_px_data;
                    frame_done_d = ptr_tc;
                end
            end
            default: ;
        endcase
        busy_d = (state_q != ST_IDLE) || (state_d != ST_IDLE);
    end

    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_we     = mem_we_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign px_drop    = px_drop_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Directed bench for fb_write_ctrl: reset, clear, capture, short frame, collision, priority.
module tb_fb_write_ctrl;

    localparam int AW   = 15;
    localparam int DW   = 12;
    localparam int NPIX = 19200;

    logic          clk = 1'b0;
    logic          reset;
    logic          capture_en;
    logic          cam_frame_start;
    logic          cam_px_valid;
    logic [DW-1:0] cam_px_data;
    logic          clear_req;
    logic [DW-1:0] clear_color;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic          busy;
    logic          frame_done;
    logic          frame_err;
    logic          px_drop;
    logic [1:0]    state_dbg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fb_write_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .capture_en      (capture_en),
        .cam_frame_start (cam_frame_start),
        .cam_px_valid    (cam_px_valid),
        .cam_px_data     (cam_px_data),
        .clear_req       (clear_req),
        .clear_color     (clear_color),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .mem_we          (mem_we),
        .busy            (busy),
        .frame_done      (frame_done),
        .frame_err       (frame_err),
        .px_drop         (px_drop),
        .state_dbg       (state_dbg)
    );

    // Write monitor: RAM model plus pulse and address-order statistics.
    logic          mon_rst;
    logic [DW-1:0] ram [NPIX];
    int            wr_cnt, seq_bad, next_addr, done_cnt, err_cnt, drop_cnt, both_cnt;
    int            first_after_err;
    logic          err_seen;

    always @(posedge clk) begin
        if (mon_rst) begin
            wr_cnt          <= 0;
            seq_bad         <= 0;
            next_addr       <= 0;
            done_cnt        <= 0;
            err_cnt         <= 0;
            drop_cnt        <= 0;
            both_cnt        <= 0;
            first_after_err <= -1;
            err_seen        <= 1'b0;
        end else begin
            if (mem_we) begin
                wr_cnt    <= wr_cnt + 1;
                next_addr <= int'(mem_addr) + 1;
                if (int'(mem_addr) != next_addr && mem_addr != '0) seq_bad <= seq_bad + 1;
                if (int'(mem_addr) < NPIX) ram[mem_addr] <= mem_data;
                if (err_seen && first_after_err < 0) first_after_err <= int'(mem_addr);
            end
            if (frame_done) done_cnt <= done_cnt + 1;
            if (frame_err) begin
                err_cnt  <= err_cnt + 1;
                err_seen <= 1'b1;
            end
            if (px_drop) drop_cnt <= drop_cnt + 1;
            if (frame_done && frame_err) both_cnt <= both_cnt + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic mon_restart();
        mon_rst = 1'b1;
        tick();
        mon_rst = 1'b0;
    endtask

    int nbad;
    int exp_drop;
    bit done_flag;

    initial begin
        reset           = 1'b1;
        capture_en      = 1'b0;
        cam_frame_start = 1'b0;
        cam_px_valid    = 1'b0;
        cam_px_data     = '0;
        clear_req       = 1'b0;
        clear_color     = '0;
        mon_rst         = 1'b1;
        repeat (3) tick();
        check("rst_we",    int'(mem_we), 0);
        check("rst_addr",  int'(mem_addr), 0);
        check("rst_data",  int'(mem_data), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(frame_done), 0);
        check("rst_err",   int'(frame_err), 0);
        check("rst_drop",  int'(px_drop), 0);
        check("rst_state", int'(state_dbg), 0);
        reset = 1'b0;
        tick();
        mon_rst = 1'b0;

        // Stray pixel in IDLE and a frame start while capture is disabled are both dropped.
        cam_px_valid = 1'b1;
        cam_px_data  = 12'h555;
        tick();
        check("idle_drop", int'(px_drop), 1);
        check("idle_we",   int'(mem_we), 0);
        cam_frame_start = 1'b1;
        tick();
        cam_frame_start = 1'b0;
        cam_px_valid    = 1'b0;
        check("noen_drop", int'(px_drop), 1);
        check("noen_busy", int'(busy), 0);

        // Reset in the middle of a clear.
        clear_req   = 1'b1;
        clear_color = 12'h0AB;
        tick();
        clear_req = 1'b0;
        check("clr_acc_busy", int'(busy), 1);
        check("clr_acc_we",   int'(mem_we), 0);
        tick();
        check("clr_w0_we",   int'(mem_we), 1);
        check("clr_w0_addr", int'(mem_addr), 0);
        check("clr_w0_data", int'(mem_data), 12'h0AB);
        repeat (2) tick();
        check("clr_w2_addr", int'(mem_addr), 2);
        reset = 1'b1;
        tick();
        check("mid_rst_we",   int'(mem_we), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_addr", int'(mem_addr), 0);
        check("mid_rst_data", int'(mem_data), 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        check("post_rst_we",   int'(mem_we), 0);
        check("post_rst_busy", int'(busy), 0);

        // Clear and frame start in the same IDLE cycle: clear wins, the frame is dropped.
        mon_restart();
        clear_req       = 1'b1;
        cam_frame_start = 1'b1;
        capture_en      = 1'b1;
        cam_px_valid    = 1'b1;
        cam_px_data     = 12'h777;
        clear_color     = 12'hF00;
        exp_drop        = 1;
        tick();
        clear_req       = 1'b0;
        cam_frame_start = 1'b0;
        clear_color     = 12'h123;
        check("prio_drop", int'(px_drop), 1);
        check("prio_we",   int'(mem_we), 0);
        check("prio_busy", int'(busy), 1);
        done_flag = 1'b0;
        for (int i = 0; i < NPIX + 100; i++) begin
            cam_px_valid = (i % 2 == 1);
            if (cam_px_valid) exp_drop++;
            tick();
            if (frame_done) begin
                done_flag = 1'b1;
                break;
            end
        end
        cam_px_valid = 1'b0;
        check("clr_done_seen", int'(done_flag), 1);
        check("clr_done_addr", int'(mem_addr), NPIX - 1);
        check("clr_done_we",   int'(mem_we), 1);
        check("clr_done_busy", int'(busy), 1);
        tick();
        check("clr_busy_fall", int'(busy), 0);
        check("clr_we_off",    int'(mem_we), 0);
        cam_px_valid = 1'b1;
        exp_drop++;
        tick();
        cam_px_valid = 1'b0;
        check("prio_frame_dropped", int'(px_drop), 1);
        tick();
        check("clr_wr_cnt",   wr_cnt, NPIX);
        check("clr_seq",      seq_bad, 0);
        check("clr_done_cnt", done_cnt, 1);
        check("clr_drop_cnt", drop_cnt, exp_drop);
        nbad = 0;
        for (int i = 0; i < NPIX; i++) if (ram[i] !== 12'hF00) nbad++;
        check("clr_ram", nbad, 0);

        // Short frame of 500 pixels, then a full frame with gaps and capture_en dropped.
        mon_restart();
        capture_en      = 1'b1;
        cam_frame_start = 1'b1;
        tick();
        cam_frame_start = 1'b0;
        check("cap_start_we",   int'(mem_we), 0);
        check("cap_start_busy", int'(busy), 1);
        for (int i = 0; i < 500; i++) begin
            cam_px_valid = 1'b1;
            cam_px_data  = DW'(i) ^ 12'hABC;
            tick();
        end
        cam_px_valid    = 1'b0;
        cam_frame_start = 1'b1;
        tick();
        cam_frame_start = 1'b0;
        check("short_err",    int'(frame_err), 1);
        check("short_err_we", int'(mem_we), 0);
        capture_en = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            if (i % 50 == 25) begin
                cam_px_valid = 1'b0;
                tick();
            end
            cam_px_valid = 1'b1;
            cam_px_data  = DW'(i);
            tick();
        end
        check("cap_done",      int'(frame_done), 1);
        check("cap_done_addr", int'(mem_addr), NPIX - 1);
        check("cap_done_err",  int'(frame_err), 0);
        tick();
        cam_px_valid = 1'b0;
        check("cap_extra_drop", int'(px_drop), 1);
        check("cap_extra_we",   int'(mem_we), 0);
        tick();
        check("cap_wr_cnt",      wr_cnt, 500 + NPIX);
        check("cap_err_cnt",     err_cnt, 1);
        check("cap_done_cnt",    done_cnt, 1);
        check("cap_first_after", first_after_err, 0);
        check("cap_seq",         seq_bad, 0);
        check("cap_both",        both_cnt, 0);
        check("cap_drop_cnt",    drop_cnt, 1);
        nbad = 0;
        for (int i = 0; i < NPIX; i++) if (ram[i] !== DW'(i)) nbad++;
        check("cap_ram", nbad, 0);

        // Clear requested at pixel 100 waits for the frame; colour sampled at clear start.
        mon_restart();
        capture_en      = 1'b1;
        cam_frame_start = 1'b1;
        tick();
        cam_frame_start = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            cam_px_valid = 1'b1;
            cam_px_data  = ~DW'(i);
            clear_req    = (i == 100);
            if (i == 100)   clear_color = 12'h0F0;
            if (i == 19000) clear_color = 12'h00F;
            tick();
        end
        cam_px_valid = 1'b0;
        clear_req    = 1'b0;
        check("col_done",      int'(frame_done), 1);
        check("col_done_addr", int'(mem_addr), NPIX - 1);
        tick();
        check("col_gap_we", int'(mem_we), 0);
        tick();
        check("col_w0_we",   int'(mem_we), 1);
        check("col_w0_addr", int'(mem_addr), 0);
        check("col_w0_data", int'(mem_data), 12'h00F);
        done_flag = 1'b0;
        for (int i = 0; i < NPIX + 100; i++) begin
            tick();
            if (frame_done) begin
                done_flag = 1'b1;
                break;
            end
        end
        check("col_clr_done", int'(done_flag), 1);
        tick();
        check("col_done_cnt", done_cnt, 2);
        check("col_wr_cnt",   wr_cnt, 2 * NPIX);
        check("col_seq",      seq_bad, 0);
        nbad = 0;
        for (int i = 0; i < NPIX; i++) if (ram[i] !== 12'h00F) nbad++;
        check("col_ram", nbad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
